rob_writeback_buffer: RTL
=========================

// Module: rob_writeback_buffer
// PURPOSE
// Reorder buffer core sitting between dispatch/CDB write-back and the commit stage.
// Allocates entries in program order at the tail and captures results broadcast
// on the CDB. Presents the head entry to commit once its value is valid, and
// supplies operand read-out for rename lookups.
// PARAMETERS
// DEPTH   8   ROB entries; power of two; tag width TW = log2(DEPTH) = 3
// DATA_W  32  result and instruction width
// REG_AW  5   architectural destination register index width
// PORTS
// clk            in   1       rising-edge clock
// rst            in   1       asynchronous, active-high reset
// flush          in   1       synchronous squash of all entries
// alloc_valid    in   1       dispatch requests an entry
// alloc_ready    out  1       entry available (= !full)
// alloc_instr    in   DATA_W  instruction word stored with the entry
// alloc_dest     in   REG_AW  destination register
// alloc_tag      out  TW      tag assigned (= tail); valid whenever alloc_ready
// cdb_valid      in   1       CDB broadcast this cycle
// cdb_tag        in   TW      ROB tag of the producing instruction
// cdb_value      in   DATA_W  result value
// commit_valid   out  1       head entry busy and value-valid
// commit_ready   in   1       commit consumes head this cycle
// commit_tag     out  TW      head pointer
// commit_dest    out  REG_AW  head destination register
// commit_value   out  DATA_W  head result
// commit_instr   out  DATA_W  head instruction word
// rd_tag         in   TW      operand lookup tag
// rd_ready       out  1       looked-up value available
// rd_value       out  DATA_W  looked-up value
// count          out  TW+1    occupied entries, 0..DEPTH
// full, empty    out  1       count==DEPTH / count==0
// BEHAVIOUR
// - Per entry: busy, vld, dest, value, instr. head, tail are TW-bit pointers that wrap
//   modulo DEPTH. count is a separate register.
// - Reset (async, rst=1): all busy/vld=0, head=tail=0, count=0. Consequently
//   commit_valid=0, alloc_ready=1, empty=1, full=0, rd_ready=0. Data outputs are
//   don't-care. Reset mid-operation discards all entries immediately.
// - Alloc fire = alloc_valid & alloc_ready: entry[tail] <= busy=1, vld=0, dest, instr;
//   tail <= tail+1. alloc_ready depends only on full; there is no same-cycle bypass
//   of a commit into a full ROB.
// - CDB: if cdb_valid & busy[cdb_tag], then value <= cdb_value and vld <= 1.
//   A write to a non-busy tag is ignored. A CDB write to the entry being allocated
//   in the same cycle is ignored; allocation wins.
// - commit_valid = busy[head] & vld[head], from registered state only. A CDB write to
//   the head is therefore visible to commit 1 cycle later. commit_* fields show
//   entry[head] combinationally.
// - Commit fire = commit_valid & commit_ready: busy/vld[head] <= 0; head <= head+1.
// - count: +1 on alloc fire only, -1 on commit fire only, unchanged when both fire.
//   Alloc and commit may fire in the same cycle at any occupancy except full,
//   where alloc is blocked.
// - rd port (combinational): if cdb_valid & cdb_tag==rd_tag & busy[rd_tag], then
//   rd_ready=1 and rd_value=cdb_value (bypass). Else rd_ready = busy & vld[rd_tag]
//   and rd_value = value[rd_tag].
// - flush (sync): same end state as reset. Flush has priority over alloc, CDB and
//   commit in that cycle, so no fire takes effect.
// - Pointer wrap: head=7 (DEPTH=8) advances to 0; full is determined by count, not
//   by pointer equality.
// TESTING
// 1 reset -> empty=1, alloc_ready=1, count=0, commit_valid=0; reset again mid-fill
//   (3 entries) -> same state.
// 2 alloc 8 entries, no CDB -> tags 0..7, full=1, alloc_ready=0; 9th alloc_valid
//   is not accepted and count stays 8.
// 3 alloc tags 0,1; CDB tag1=0xBEEF -> commit_valid=0. Then CDB tag0=0x1234 ->
//   next cycle commit_valid=1, value=0x1234; with commit_ready held, the following
//   cycle commits tag1 with 0xBEEF.
// 4 full ROB with head valid, commit_ready=1 and alloc_valid=1 in the same cycle ->
//   commit fires, alloc blocked, count=7; next cycle alloc gets tag 0 (tail wrap).
// 5 rd_tag=2 while CDB broadcasts tag2=0xCAFE -> rd_ready=1, rd_value=0xCAFE in
//   that same cycle; a CDB to a non-busy tag 5 -> no state change.
// 6 4 busy entries, flush=1 together with alloc and commit fire -> next cycle
//   count=0, head=tail=0, commit_valid=0.

Source files
------------

// File: rtl/rob_writeback_buffer.sv
// Reorder buffer core: in-order allocation at tail, CDB result capture,
// in-order commit from head and combinational operand read-out.
module rob_writeback_buffer #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  localparam int TW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [DATA_W-1:0] alloc_instr,
  input  logic [REG_AW-1:0] alloc_dest,
  output logic [TW-1:0]     alloc_tag,
  input  logic              cdb_valid,
  input  logic [TW-1:0]     cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  output logic              commit_valid,
  input  logic              commit_ready,
  output logic [TW-1:0]     commit_tag,
  output logic [REG_AW-1:0] commit_dest,
  output logic [DATA_W-1:0] commit_value,
  output logic [DATA_W-1:0] commit_instr,
  input  logic [TW-1:0]     rd_tag,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_value,
  output logic [TW:0]       count,
  output logic              full,
  output logic              empty
);

  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  vld;
  logic [REG_AW-1:0] dest_q  [DEPTH];
  logic [DATA_W-1:0] value_q [DEPTH];
  logic [DATA_W-1:0] instr_q [DEPTH];

  logic [TW-1:0] head;
  logic [TW-1:0] tail;

  logic alloc_fire;
  logic commit_fire;
  logic cdb_wr;
  logic rd_byp;

  assign full        = (count == (TW+1)'(DEPTH));
  assign empty       = (count == '0);
  assign alloc_ready = ~full;
  assign alloc_tag   = tail;
  assign alloc_fire  = alloc_valid & alloc_ready;

  assign commit_valid = busy[head] & vld[head];
  assign commit_fire  = commit_valid & commit_ready;
  assign commit_tag   = head;
  assign commit_dest  = dest_q[head];
  assign commit_value = value_q[head];
  assign commit_instr = instr_q[head];

  // Allocation owns the tail entry this cycle, so a racing CDB write loses.
  assign cdb_wr = cdb_valid & busy[cdb_tag]
                & ~(alloc_fire & (cdb_tag == tail));

  assign rd_byp   = cdb_valid & (cdb_tag == rd_tag) & busy[rd_tag];
  assign rd_ready = rd_byp | (busy[rd_tag] & vld[rd_tag]);
  assign rd_value = rd_byp ? cdb_value : value_q[rd_tag];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= '0;
      vld   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      busy  <= '0;
      vld   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc_fire) begin
        busy[tail] <= 1'b1;
        vld[tail]  <= 1'b0;
        tail       <= tail + TW'(1);
      end
      if (cdb_wr)
        vld[cdb_tag] <= 1'b1;
      // Commit clears last so a same-cycle CDB hit on head cannot revive it.
      if (commit_fire) begin
        busy[head] <= 1'b0;
        vld[head]  <= 1'b0;
        head       <= head + TW'(1);
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count <= count + (TW+1)'(1);
        2'b01:   count <= count - (TW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      dest_q[tail]  <= alloc_dest;
      instr_q[tail] <= alloc_instr;
    end
    if (cdb_wr)
      value_q[cdb_tag] <= cdb_value;
  end

endmodule
